serial_compare_ctrl: RTL and testbench
======================================

# serial_compare_ctrl

Sequencer that compares two WIDTH-bit unsigned operands one bit per cycle, MSB first, using an external 1-bit equality comparator (x, y → z, z = 1 when x == y). The block holds the operands, drives one bit pair per cycle onto the comparator and reads back its match flag. It stops at the first mismatch and reports equal, greater or less through a start/busy/done handshake. It sits between the control logic that issues compare requests and the 1-bit comparator datapath.

## Interface
- WIDTH, default 8: operand width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- start  in  1  request a compare; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cmp_x  out  1  bit of A presented to the comparator x input.
- cmp_y  out  1  bit of B presented to the comparator y input.
- cmp_z  in  1  comparator result, combinational from cmp_x/cmp_y; 1 = bits equal.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- eq, gt, lt  out  1 each  result flags, one-hot once valid, held until the next accepted start.
- bits_cmp  out  $clog2(WIDTH)+1  number of bit pairs examined in the last compare (1..WIDTH).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start = 1: load a_sh ← a and b_sh ← b, set idx ← WIDTH-1, clear eq/gt/lt/bits_cmp, go to RUN.
  - start = 0: stay in IDLE.
- RUN:
  - cmp_x = a_sh[WIDTH-1] and cmp_y = b_sh[WIDTH-1], both driven from registers.
  - Each cycle, sample cmp_z at the edge and increment bits_cmp.
  - If cmp_z = 0 (mismatch): gt ← cmp_x, lt ← cmp_y, eq ← 0, go to DONE.
  - Else if idx = 0: eq ← 1, go to DONE.
  - Otherwise: shift a_sh and b_sh left by 1, decrement idx, stay in RUN.
- DONE: done = 1 for exactly this one cycle, then unconditionally return to IDLE.
- cmp_x and cmp_y are 0 in IDLE and DONE.
- start is ignored while busy = 1, including in DONE. Back-to-back compares therefore need start held or re-asserted in the IDLE cycle.
- The block trusts cmp_z. If cmp_z = 0 while cmp_x == cmp_y (faulty datapath), it still records a mismatch: gt = cmp_x, lt = cmp_y. For a = b bits, both are equal in that case, so the bench flags it as a datapath fault.
- Operand inputs a and b are not observed after the accepting edge.

## Timing
- Reset (asynchronous, immediate): state = IDLE; busy, done, eq, gt, lt, cmp_x, cmp_y = 0; bits_cmp = 0; a_sh, b_sh, idx = 0.
- Reset asserted mid-RUN aborts the compare with no done pulse. The first start after reset release is accepted normally.
- Start accepted at edge E0. RUN occupies cycles E0..E(n-1), where n = bit position of the first mismatch counted from the MSB (1-based), or n = WIDTH if the operands are equal.
- done is high during the cycle following edge En, i.e. n cycles after the accepting edge. busy is high over the same span and includes the DONE cycle.
- Earliest next accept: the edge ending the IDLE cycle after DONE. Minimum turnaround between starts is n+2 edges.
- cmp_x/cmp_y change only at edges. The comparator path cmp_x/cmp_y → cmp_z → state logic must meet one clk period.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5, start pulse → busy for 9 cycles; done 8 cycles after accept; eq=1, gt=0, lt=0, bits_cmp=8.
- a=0x80, b=0x00 → mismatch on the first bit; done 1 cycle after accept; gt=1, bits_cmp=1; cmp_x=1 and cmp_y=0 during the single RUN cycle.
- a=0x12, b=0x13 → lt=1 after 8 RUN cycles, bits_cmp=8. The cmp_x/cmp_y sequence matches the MSB-first bits of each operand.
- During the compare of 0xF0 vs 0x0F, assert start with a=b=0x00 → second request ignored; result gt=1 and bits_cmp=1 belong to the first request; results held through IDLE until the next accept.
- Assert rst_n=0 on the 4th RUN cycle of 0x01 vs 0x00 → all outputs 0 immediately, no done. After release, start 0x00 vs 0x01 → lt=1, bits_cmp=8.
- Force cmp_z=0 with a=b=0x55 → done after 1 cycle, gt=lt=0 (cmp_x=cmp_y=0 on bit 7), eq=0; bench reports a datapath fault.

Source files
------------

// File: rtl/serial_compare_ctrl_if.sv
// Bundle between the compare requester, the sequencer and the 1-bit equality comparator.
// master = requester, slave = sequencer, datapath = external comparator.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                     start;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     cmp_x;
    logic                     cmp_y;
    logic                     cmp_z;
    logic                     busy;
    logic                     done;
    logic                     eq;
    logic                     gt;
    logic                     lt;
    logic [$clog2(WIDTH):0]   bits_cmp;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt, bits_cmp
    );

    modport slave (
        input  start, a, b, cmp_z,
        output cmp_x, cmp_y, busy, done, eq, gt, lt, bits_cmp
    );

    modport datapath (
        input  cmp_x, cmp_y,
        output cmp_z
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude compare of two operands through an external 1-bit
// equality comparator; stops at the first mismatching bit pair.
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | one bit pair per cycle on cmp_x/cmp_y
//   DONE  | one-cycle done pulse, start ignored
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_compare_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IW-1:0]    idx;
    logic [BW-1:0]    bits_cmp;
    logic             eq;
    logic             gt;
    logic             lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (!bus.cmp_z || idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            idx      <= '0;
            bits_cmp <= '0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        idx      <= IW'(WIDTH - 1);
                        bits_cmp <= '0;
                        eq       <= 1'b0;
                        gt       <= 1'b0;
                        lt       <= 1'b0;
                    end
                end
                RUN: begin
                    bits_cmp <= bits_cmp + BW'(1);
                    // cmp_z is trusted even when the presented bits agree
                    if (!bus.cmp_z) begin
                        gt <= a_sh[WIDTH-1];
                        lt <= b_sh[WIDTH-1];
                        eq <= 1'b0;
                    end else if (idx == '0) begin
                        eq <= 1'b1;
                    end else begin
                        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                        b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                        idx  <= idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmp_x    = (state == RUN) & a_sh[WIDTH-1];
    assign bus.cmp_y    = (state == RUN) & b_sh[WIDTH-1];
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.eq       = eq;
    assign bus.gt       = gt;
    assign bus.lt       = lt;
    assign bus.bits_cmp = bits_cmp;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: directed vector table, hand-built corner
// sequences, then random operands against a magnitude-compare reference model.
module tb_serial_compare_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    logic fault_z;
    int   n_total;
    int   n_pass;

    serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Ideal 1-bit equality comparator, optionally stuck at "mismatch"
    assign bus.cmp_z = fault_z ? 1'b0 : (bus.cmp_x ~^ bus.cmp_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               fault;
        bit               eq;
        bit               gt;
        bit               lt;
        int               n;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: plain magnitude compare, n = 1-based position of the first differing bit from the MSB
    task automatic model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                         output bit meq, output bit mgt, output bit mlt, output int mn);
        logic [WIDTH-1:0] diff;
        meq  = (ra == rb);
        mgt  = (ra > rb);
        mlt  = (ra < rb);
        diff = ra ^ rb;
        mn   = WIDTH;
        for (int i = 0; i < WIDTH; i++)
            if (diff[i]) mn = WIDTH - i;
    endtask

    task automatic do_compare(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv, input bit fault,
                              input bit xeq, input bit xgt, input bit xlt, input int xn, input string tag);
        int cyc;
        @(negedge clk);
        fault_z   = fault;
        bus.a     = ta;
        bus.b     = tbv;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (!bus.done && cyc <= WIDTH + 2) begin
            chk({tag, " busy_run"}, bus.busy, 1);
            chk({tag, " bits_run"}, bus.bits_cmp, cyc - 1);
            if (cyc <= xn) begin
                chk({tag, " cmp_x"}, bus.cmp_x, ta[WIDTH-cyc]);
                chk({tag, " cmp_y"}, bus.cmp_y, tbv[WIDTH-cyc]);
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_seen"}, bus.done, 1);
        chk({tag, " latency"}, cyc - 1, xn);
        chk({tag, " busy_done"}, bus.busy, 1);
        chk({tag, " cmp_x_done"}, {bus.cmp_x, bus.cmp_y}, 0);
        chk({tag, " flags"}, {bus.eq, bus.gt, bus.lt}, {xeq, xgt, xlt});
        chk({tag, " bits_cmp"}, bus.bits_cmp, xn);
        if (fault && !bus.eq && (bus.gt == bus.lt))
            $display("note: datapath fault on %s (mismatch reported with equal bits)", tag);
        @(negedge clk);
        fault_z = 1'b0;
        chk({tag, " done_pulse"}, {bus.done, bus.busy}, 0);
        chk({tag, " held"}, {bus.eq, bus.gt, bus.lt, 4'(bus.bits_cmp)}, {xeq, xgt, xlt, 4'(xn)});
    endtask

    initial begin
        bit   meq, mgt, mlt;
        int   mn;
        logic [WIDTH-1:0] ra, rb;

        n_total   = 0;
        n_pass    = 0;
        fault_z   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;

        vecs.push_back('{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8});
        vecs.push_back('{8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8});
        vecs.push_back('{8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{8'hFF, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 8});
        vecs.push_back('{8'h3C, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 5});
        vecs.push_back('{8'h55, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1});

        #12;
        chk("reset_outputs", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.cmp_x, bus.cmp_y}, 0);
        chk("reset_bits", bus.bits_cmp, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_compare(vecs[i].a, vecs[i].b, vecs[i].fault, vecs[i].eq, vecs[i].gt, vecs[i].lt,
                       vecs[i].n, $sformatf("vec%0d", i));

        // Second request during RUN and DONE must be ignored
        @(negedge clk);
        bus.a = 8'hF0; bus.b = 8'h0F; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("ign run", bus.busy, 1);
        bus.a = 8'h00; bus.b = 8'h00; bus.start = 1'b1;
        @(negedge clk);
        chk("ign done", bus.done, 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("ign idle_busy", bus.busy, 0);
        chk("ign flags", {bus.eq, bus.gt, bus.lt}, 3'b010);
        chk("ign bits", bus.bits_cmp, 1);
        repeat (3) @(negedge clk);
        chk("ign still_idle", bus.busy, 0);
        chk("ign held", {bus.eq, bus.gt, bus.lt, 4'(bus.bits_cmp)}, {3'b010, 4'd1});

        // Reset on the 4th RUN cycle aborts with no done
        bus.a = 8'h01; bus.b = 8'h00; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst run4_bits", bus.bits_cmp, 3);
        rst_n = 1'b0;
        #1;
        chk("rst abort_outputs", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.cmp_x, bus.cmp_y}, 0);
        chk("rst abort_bits", bus.bits_cmp, 0);
        @(negedge clk);
        chk("rst no_done", bus.done, 0);
        rst_n = 1'b1;
        do_compare(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8, "post_rst");

        for (int k = 0; k < 25; k++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            model(ra, rb, meq, mgt, mlt, mn);
            do_compare(ra, rb, 1'b0, meq, mgt, mlt, mn, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
